// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES core: block width, round counts
// for the three key sizes, round-key index width and the controller state
// encoding.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;
    localparam int RK_IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WHITEN = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_ctrl_state_e;

    // True when the round counter has reached the last round of the cipher.
    function automatic logic is_final_round(input logic [RK_IDX_W-1:0] round,
                                            input int                  nr);
        return (round == RK_IDX_W'(nr));
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES encryption sequencer. Holds the 128-bit cipher state and the
// round counter, applies initial whitening with round key 0, then steps an
// external combinational round datapath once per cycle for NR rounds.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   in_valid/ready  : plaintext handshake, in_data sampled on accept
//   out_valid/ready : ciphertext handshake, out_data held until accepted
//   rk_idx / rk     : round-key request to key store, combinational return
//   rnd_state       : state presented to the round datapath
//   rnd_final       : last round, datapath must skip mix_columns
//   rnd_result      : round datapath output, combinational return
//   busy            : high while whitening or running rounds
// -----------------------------------------------------------------------------
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR_128,
    parameter int BLK_W = AES_BLK_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLK_W-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLK_W-1:0]    out_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [BLK_W-1:0]    rk,
    output logic [BLK_W-1:0]    rnd_state,
    output logic                rnd_final,
    input  logic [BLK_W-1:0]    rnd_result,
    output logic                busy
);

    aes_ctrl_state_e     r_state;
    aes_ctrl_state_e     w_state_next;
    logic [RK_IDX_W-1:0] r_round;
    logic [RK_IDX_W-1:0] w_round_next;
    logic [BLK_W-1:0]    r_data;
    logic [BLK_W-1:0]    w_data_next;

    logic [BLK_W-1:0]    w_whiten;
    logic                w_last;

    // Initial whitening: bytewise XOR of the loaded plaintext with key 0.
    genvar gi;
    generate
        for (gi = 0; gi < BLK_W / 8; gi++) begin : g_whiten
            assign w_whiten[gi*8 +: 8] = r_data[gi*8 +: 8] ^ rk[gi*8 +: 8];
        end
    endgenerate

    assign w_last = is_final_round(r_round, NR);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_round_next = r_round;
        w_data_next  = r_data;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_next  = in_data;
                    w_state_next = WHITEN;
                end
            end
            WHITEN: begin
                w_data_next  = w_whiten;
                w_round_next = RK_IDX_W'(1);
                w_state_next = ROUND;
            end
            ROUND: begin
                w_data_next = rnd_result;
                if (w_last) begin
                    // Counter stays at NR while the result waits in DONE.
                    w_state_next = DONE;
                end else begin
                    w_round_next = r_round + RK_IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_round_next = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_round <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_round <= w_round_next;
            r_data  <= w_data_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_data;
    assign busy      = (r_state == WHITEN) || (r_state == ROUND);

    // Outside the active states the key store and datapath see index 0,
    // a non-final round and the held state.
    assign rk_idx    = (r_state == ROUND) ? r_round : '0;
    assign rnd_final = (r_state == ROUND) && w_last;
    assign rnd_state = r_data;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl. An NR=10 instance is driven either
// by a mock datapath (result = state ^ key, key = index replicated) or by a
// behavioural AES round with a FIPS-197 key schedule; an NR=14 instance uses
// the mock datapath. Expected results come from a block-level model.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int TB_NR   = 10;
    localparam int TB_NR14 = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- NR=10 instance signals ----------------
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] rnd_state;
    logic         rnd_final;
    logic [127:0] rnd_result;
    logic         busy;

    // ---------------- NR=14 instance signals ----------------
    logic         iv14;
    logic         ir14;
    logic [127:0] id14;
    logic         ov14;
    logic         or14;
    logic [127:0] od14;
    logic [3:0]   rki14;
    logic [127:0] rk14;
    logic [127:0] rs14;
    logic         rf14;
    logic [127:0] rr14;
    logic         busy14;

    logic         tb_mode = 1'b0;   // 0 = mock datapath, 1 = AES datapath
    logic [7:0]   sbox [256];
    logic [127:0] ks   [16];

    aes_round_ctrl #(.NR(TB_NR), .BLK_W(128)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rk_idx(rk_idx), .rk(rk),
        .rnd_state(rnd_state), .rnd_final(rnd_final), .rnd_result(rnd_result),
        .busy(busy)
    );

    aes_round_ctrl #(.NR(TB_NR14), .BLK_W(128)) dut14 (
        .clk(clk), .rst(rst),
        .in_valid(iv14), .in_ready(ir14), .in_data(id14),
        .out_valid(ov14), .out_ready(or14), .out_data(od14),
        .rk_idx(rki14), .rk(rk14),
        .rnd_state(rs14), .rnd_final(rf14), .rnd_result(rr14),
        .busy(busy14)
    );

    // ---------------- AES helper functions ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] aes_round_f(input logic [127:0] st,
                                                 input logic [127:0] k,
                                                 input logic         fin);
        logic [7:0]   a [16];
        logic [7:0]   s [16];
        logic [7:0]   m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[st[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r + 4*c] = a[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c+0] = xtime(s[4*c]) ^ xtime(s[4*c+1]) ^ s[4*c+1] ^ s[4*c+2] ^ s[4*c+3];
            m[4*c+1] = s[4*c] ^ xtime(s[4*c+1]) ^ xtime(s[4*c+2]) ^ s[4*c+2] ^ s[4*c+3];
            m[4*c+2] = s[4*c] ^ s[4*c+1] ^ xtime(s[4*c+2]) ^ xtime(s[4*c+3]) ^ s[4*c+3];
            m[4*c+3] = xtime(s[4*c]) ^ s[4*c] ^ s[4*c+1] ^ s[4*c+2] ^ xtime(s[4*c+3]);
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = fin ? s[i] : m[i];
        return o ^ k;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_keys(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            ks[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // ---------------- datapath / key store stand-ins ----------------
    always_comb begin
        if (tb_mode) begin
            rk         = ks[rk_idx];
            rnd_result = aes_round_f(rnd_state, rk, rnd_final);
        end else begin
            rk         = {32{rk_idx}};
            rnd_result = rnd_state ^ rk;
        end
    end

    always_comb begin
        rk14 = {32{rki14}};
        rr14 = rs14 ^ rk14;
    end

    // Block-level model of the mock cipher: every key 0..nr XORed onto the block.
    function automatic logic [127:0] mock_expect(input logic [127:0] pt, input int nr);
        logic [127:0] acc;
        logic [3:0]   n4;
        acc = pt;
        for (int i = 0; i <= nr; i++) begin
            n4  = 4'(i);
            acc = acc ^ {32{n4}};
        end
        return acc;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    // Offers one block in IDLE, then observes it until out_valid (no handshake).
    task automatic run_block(input  logic [127:0] pt,
                             output int           lat,
                             output int           idx_err,
                             output int           n_final,
                             output int           busy_err,
                             output logic [127:0] res);
        in_data  = pt;
        in_valid = 1'b1;
        wait_edge();
        in_valid = 1'b0;
        in_data  = rand128();
        lat      = 0;
        idx_err  = 0;
        n_final  = 0;
        busy_err = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (rk_idx !== 4'(lat)) idx_err++;
            if (rnd_final === 1'b1) begin
                n_final++;
                if (rk_idx !== 4'(TB_NR)) idx_err++;
            end
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_err++;
            wait_edge();
            lat++;
        end
        res = out_data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        iv14 = 1'b0; id14 = '0; or14 = 1'b0;
        wait_edge();
        wait_edge();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rk_idx !== 4'h0) begin errors++; $display("FAIL reset_rk_idx: got %h want 0", rk_idx); end
        checks++; if (rnd_final !== 1'b0) begin errors++; $display("FAIL reset_rnd_final: got %b want 0", rnd_final); end
        $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_mock_blocks();
        logic [127:0] pt, exp_ct, res;
        int lat, idx_err, n_final, busy_err;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            pt     = (b == 0) ? 128'h0 : rand128();
            exp_ct = mock_expect(pt, TB_NR);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mock_in_ready_idle: got %b want 1", in_ready); end
            run_block(pt, lat, idx_err, n_final, busy_err, res);
            checks++; if (res !== exp_ct) begin errors++; $display("FAIL mock_out_data: got %h want %h", res, exp_ct); end
            checks++; if (lat !== TB_NR + 1) begin errors++; $display("FAIL mock_latency: got %0d want %0d", lat, TB_NR + 1); end
            checks++; if (idx_err !== 0) begin errors++; $display("FAIL mock_rk_idx_seq: got %0d errors want 0", idx_err); end
            checks++; if (n_final !== 1) begin errors++; $display("FAIL mock_rnd_final_count: got %0d want 1", n_final); end
            checks++; if (busy_err !== 0) begin errors++; $display("FAIL mock_busy: got %0d bad cycles want 0", busy_err); end
            $display("mock blk %0d pt=%h ct=%h lat=%0d", b, pt, res, lat);
            wait_edge();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mock_return_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        end
    endtask

    task automatic test_fips();
        logic [127:0] res;
        int lat, idx_err, n_final, busy_err;
        build_keys(128'h000102030405060708090a0b0c0d0e0f);
        tb_mode   = 1'b1;
        out_ready = 1'b1;
        wait_edge();
        run_block(128'h00112233445566778899aabbccddeeff, lat, idx_err, n_final, busy_err, res);
        checks++; if (res !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL fips_out_data: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", res); end
        checks++; if (lat !== TB_NR + 1) begin errors++; $display("FAIL fips_latency: got %0d want %0d", lat, TB_NR + 1); end
        $display("fips ct=%h lat=%0d", res, lat);
        wait_edge();
        tb_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, pt2, res;
        int lat, idx_err, n_final, busy_err;
        pt  = rand128();
        pt2 = rand128();
        out_ready = 1'b0;
        run_block(pt, lat, idx_err, n_final, busy_err, res);
        checks++; if (res !== mock_expect(pt, TB_NR)) begin errors++; $display("FAIL bp_first_data: got %h want %h", res, mock_expect(pt, TB_NR)); end
        in_valid = 1'b1;
        in_data  = pt2;
        for (int c = 0; c < 5; c++) begin
            wait_edge();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_hold: got %b want 1", out_valid); end
            checks++; if (out_data !== res) begin errors++; $display("FAIL bp_out_data_hold: got %h want %h", out_data, res); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        end
        out_ready = 1'b1;
        wait_edge();    // output handshake edge
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_early_accept: got busy=%b in_ready=%b out_valid=%b want 0/1/0", busy, in_ready, out_valid); end
        wait_edge();    // accept edge for pt2
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept_after: got busy=%b want 1", busy); end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            wait_edge();
            lat++;
        end
        checks++; if (lat !== TB_NR + 1) begin errors++; $display("FAIL bp_second_latency: got %0d want %0d", lat, TB_NR + 1); end
        checks++; if (out_data !== mock_expect(pt2, TB_NR)) begin errors++; $display("FAIL bp_second_data: got %h want %h", out_data, mock_expect(pt2, TB_NR)); end
        $display("backpressure blk1 ct=%h blk2 ct=%h", res, out_data);
        wait_edge();
    endtask

    task automatic test_reset_mid_block();
        logic [127:0] pt, res;
        int lat, idx_err, n_final, busy_err, guard, spurious;
        out_ready = 1'b1;
        pt        = rand128();
        in_data   = pt;
        in_valid  = 1'b1;
        wait_edge();
        in_valid = 1'b0;
        guard    = 0;
        while (!(busy === 1'b1 && rk_idx === 4'd5) && guard < 20) begin
            wait_edge();
            guard++;
        end
        checks++; if (guard >= 20) begin errors++; $display("FAIL rstmid_reach_round5: got timeout want rk_idx=5"); end
        rst = 1'b1;
        wait_edge();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        spurious = 0;
        for (int c = 0; c < 15; c++) begin
            wait_edge();
            if (out_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL rstmid_no_output: got %0d valid cycles want 0", spurious); end
        pt = rand128();
        run_block(pt, lat, idx_err, n_final, busy_err, res);
        checks++; if (lat !== TB_NR + 1) begin errors++; $display("FAIL rstmid_new_latency: got %0d want %0d", lat, TB_NR + 1); end
        checks++; if (res !== mock_expect(pt, TB_NR)) begin errors++; $display("FAIL rstmid_new_data: got %h want %h", res, mock_expect(pt, TB_NR)); end
        $display("reset-mid new blk pt=%h ct=%h lat=%0d", pt, res, lat);
        wait_edge();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [3];
        int           acc_t [3];
        int           k, outs;
        logic         acc;
        for (int i = 0; i < 3; i++) pts[i] = rand128();
        k = 0; outs = 0;
        out_ready = 1'b1;
        in_data   = pts[0];
        in_valid  = 1'b1;
        for (int c = 0; c < 60 && outs < 3; c++) begin
            acc = in_valid && in_ready;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++; if (out_data !== mock_expect(pts[outs], TB_NR)) begin errors++; $display("FAIL b2b_out_data_%0d: got %h want %h", outs, out_data, mock_expect(pts[outs], TB_NR)); end
                $display("b2b out %0d ct=%h cycle=%0d", outs, out_data, c);
                outs++;
            end
            wait_edge();
            if (acc) begin
                acc_t[k] = c;
                k++;
                if (k < 3) in_data = pts[k];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (outs !== 3 || k !== 3) begin errors++; $display("FAIL b2b_count: got %0d outs %0d accepts want 3/3", outs, k); end
        if (k == 3) begin
            checks++; if (acc_t[1] - acc_t[0] !== TB_NR + 3) begin errors++; $display("FAIL b2b_gap01: got %0d want %0d", acc_t[1] - acc_t[0], TB_NR + 3); end
            checks++; if (acc_t[2] - acc_t[1] !== TB_NR + 3) begin errors++; $display("FAIL b2b_gap12: got %0d want %0d", acc_t[2] - acc_t[1], TB_NR + 3); end
        end
        wait_edge();
    endtask

    task automatic test_nr14();
        logic [127:0] pt;
        int lat, n_final;
        or14 = 1'b1;
        for (int b = 0; b < 2; b++) begin
            pt   = (b == 0) ? 128'h0 : rand128();
            id14 = pt;
            iv14 = 1'b1;
            wait_edge();
            iv14    = 1'b0;
            id14    = rand128();
            lat     = 0;
            n_final = 0;
            while (ov14 !== 1'b1 && lat < 40) begin
                if (rf14 === 1'b1) n_final++;
                wait_edge();
                lat++;
            end
            checks++; if (lat !== TB_NR14 + 1) begin errors++; $display("FAIL nr14_latency: got %0d want %0d", lat, TB_NR14 + 1); end
            checks++; if (od14 !== mock_expect(pt, TB_NR14)) begin errors++; $display("FAIL nr14_out_data: got %h want %h", od14, mock_expect(pt, TB_NR14)); end
            checks++; if (n_final !== 1) begin errors++; $display("FAIL nr14_rnd_final_count: got %0d want 1", n_final); end
            $display("nr14 blk %0d pt=%h ct=%h lat=%0d", b, pt, od14, lat);
            wait_edge();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_mock_blocks();
        test_fips();
        test_backpressure();
        test_reset_mid_block();
        test_back_to_back();
        test_nr14();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
